// File: rtl/bsg_fpu_class_stats.sv
// Per-class saturating occurrence counters fed by the fclass vector, with a random-access read port.
// Latency: an accepted input is visible to a read issued in the next cycle; reads return data 1 cycle after the request.
// Backpressure: ready_o drops only during the clear sweep (11 cycles, or 12 with BSG_FPU_CLASS_STATS_TOTAL_EN); reads never stall.
//
// Configuration macro: BSG_FPU_CLASS_STATS_TOTAL_EN adds a saturating total counter at entry 11.
module bsg_fpu_class_stats #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [15:0]        class_i,
  output logic               ready_o,
  input  logic               clear_i,
  input  logic               rd_v_i,
  input  logic [3:0]         rd_idx_i,
  output logic               rd_v_o,
  output logic [width_p-1:0] rd_data_o
);

`ifdef BSG_FPU_CLASS_STATS_TOTAL_EN
  localparam int num_entries_lp = 12;
`else
  localparam int num_entries_lp = 11;
`endif
  localparam logic [3:0] last_idx_lp = 4'(num_entries_lp - 1);
  localparam int malformed_idx_lp = 10;

  typedef enum logic {eRun, eClear} state_e;

  state_e                    state_r;
  logic [3:0]                sweep_idx_r;
  logic [width_p-1:0]        cnt_r [num_entries_lp];
  logic [num_entries_lp-1:0] inc_vec;
  logic [width_p-1:0]        rd_mux;
  logic                      accept;
  logic                      well_formed;

  // Ready comes straight from the registered state, so it has no path from v_i or clear_i.
  assign ready_o = (state_r == eRun);
  assign accept  = v_i & ready_o;

  // A legal vector has nothing in the reserved upper bits and exactly one class bit set.
  assign well_formed = (class_i[15:10] == 6'd0)
                     && (class_i[9:0] != 10'd0)
                     && ((class_i[9:0] & (class_i[9:0] - 10'd1)) == 10'd0);

  // Decode which counters an accepted input bumps: one class counter or the malformed counter, plus total if built.
  always_comb begin
    inc_vec = '0;
    if (accept) begin
      if (well_formed) begin
        inc_vec[9:0] = class_i[9:0];
      end else begin
        inc_vec[malformed_idx_lp] = 1'b1;
      end
`ifdef BSG_FPU_CLASS_STATS_TOTAL_EN
      inc_vec[11] = 1'b1;
`endif
    end
  end

  // Clear sequencer: a clear request in eRun starts a one-entry-per-cycle sweep; clear_i is ignored mid-sweep.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= eRun;
      sweep_idx_r <= 4'd0;
    end else begin
      case (state_r)
        eRun: begin
          sweep_idx_r <= 4'd0;
          if (clear_i) begin
            state_r <= eClear;
          end
        end
        eClear: begin
          if (sweep_idx_r == last_idx_lp) begin
            state_r     <= eRun;
            sweep_idx_r <= 4'd0;
          end else begin
            sweep_idx_r <= sweep_idx_r + 4'd1;
          end
        end
        default: begin
          state_r     <= eRun;
          sweep_idx_r <= 4'd0;
        end
      endcase
    end
  end

  // Counter file: the sweep zeroes one entry per cycle; otherwise increment and stick at all-ones.
  // Accepts only happen in eRun, so a sweep write never competes with an increment.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_entries_lp; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < num_entries_lp; i++) begin
        if ((state_r == eClear) && (sweep_idx_r == 4'(i))) begin
          cnt_r[i] <= '0;
        end else if (inc_vec[i] && (cnt_r[i] != '1)) begin
          cnt_r[i] <= cnt_r[i] + width_p'(1);
        end
      end
    end
  end

  // Read mux over the stored values; indices past the implemented entries read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < num_entries_lp; i++) begin
      if (rd_idx_i == 4'(i)) begin
        rd_mux = cnt_r[i];
      end
    end
  end

  // Registered read port: data is the pre-update value at the request edge and holds while idle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_v_o    <= 1'b0;
      rd_data_o <= '0;
    end else begin
      rd_v_o <= rd_v_i;
      if (rd_v_i) begin
        rd_data_o <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_bsg_fpu_class_stats.sv
// Directed bench for bsg_fpu_class_stats: table of accept/read/reset steps plus hand-written clear,
// collision, saturation and async-reset sequences. A second instance with width_p = 2 covers saturation.
module tb_bsg_fpu_class_stats;

`ifdef BSG_FPU_CLASS_STATS_TOTAL_EN
  localparam int n_ent = 12;
  localparam logic [15:0] exp_total_malformed = 16'd3;
`else
  localparam int n_ent = 11;
  localparam logic [15:0] exp_total_malformed = 16'd0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        v_i = 1'b0;
  logic [15:0] class_i = 16'h0;
  logic        ready_o;
  logic        clear_i = 1'b0;
  logic        rd_v_i = 1'b0;
  logic [3:0]  rd_idx_i = 4'd0;
  logic        rd_v_o;
  logic [15:0] rd_data_o;

  logic        v2 = 1'b0;
  logic [15:0] cls2 = 16'h0;
  logic        ready2;
  logic        clear2 = 1'b0;
  logic        rd2_v_i = 1'b0;
  logic [3:0]  rd2_idx = 4'd0;
  logic        rd2_v_o;
  logic [1:0]  rd2_data;

  int n_pass = 0;
  int n_total = 0;

  bsg_fpu_class_stats #(.width_p(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .class_i(class_i), .ready_o(ready_o),
    .clear_i(clear_i), .rd_v_i(rd_v_i), .rd_idx_i(rd_idx_i), .rd_v_o(rd_v_o), .rd_data_o(rd_data_o)
  );

  bsg_fpu_class_stats #(.width_p(2)) dut2 (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v2), .class_i(cls2), .ready_o(ready2),
    .clear_i(clear2), .rd_v_i(rd2_v_i), .rd_idx_i(rd2_idx), .rd_v_o(rd2_v_o), .rd_data_o(rd2_data)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          rst;
    bit          acc;
    logic [15:0] cls;
    bit          rd;
    logic [3:0]  idx;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit acc, logic [15:0] cls, bit rd, logic [3:0] idx, logic [15:0] exp);
    vec_t v;
    v.rst = rst; v.acc = acc; v.cls = cls; v.rd = rd; v.idx = idx; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    #4;
    reset_i = 1'b0;
    tick();
  endtask

  task automatic acc(input logic [15:0] cls);
    v_i = 1'b1; class_i = cls;
    tick();
    v_i = 1'b0; class_i = 16'h0;
  endtask

  task automatic rd(input logic [3:0] idx, input logic [15:0] exp, input string name);
    rd_v_i = 1'b1; rd_idx_i = idx;
    tick();
    rd_v_i = 1'b0;
    chk({name, "_v"}, {31'd0, rd_v_o}, 32'd1);
    chk(name, {16'd0, rd_data_o}, {16'd0, exp});
  endtask

  initial begin
    int k;

    // Reset state, checked between release and the first clock edge.
    #12;
    reset_i = 1'b0;
    #1;
    chk("rst_rd_v", {31'd0, rd_v_o}, 32'd0);
    chk("rst_rd_data", {16'd0, rd_data_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    tick();

    // Saturation on the 2-bit instance: 5 hits of class 4 stick at 3.
    for (int i = 0; i < 5; i++) begin
      v2 = 1'b1; cls2 = 16'h0010;
      tick();
    end
    v2 = 1'b0; cls2 = 16'h0;
    rd2_v_i = 1'b1; rd2_idx = 4'd4;
    tick();
    rd2_v_i = 1'b0;
    chk("sat_v", {31'd0, rd2_v_o}, 32'd1);
    chk("sat_data", {30'd0, rd2_data}, 32'd3);

    // Table: increment/readback, then malformed handling after a reset.
    do_reset();
    tbl.push_back(mk(0, 1, 16'h0001, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0001, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0001, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0200, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0, 1, 4'd0, 16'd3));
    tbl.push_back(mk(0, 0, 16'h0, 1, 4'd9, 16'd1));
    tbl.push_back(mk(0, 0, 16'h0, 1, 4'd4, 16'd0));
    tbl.push_back(mk(1, 0, 16'h0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0003, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0400, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0, 1, 4'd10, 16'd3));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 0, 16'h0, 1, 4'(i), 16'd0));
    tbl.push_back(mk(0, 0, 16'h0, 1, 4'd11, exp_total_malformed));
    tbl.push_back(mk(0, 0, 16'h0, 1, 4'd12, 16'd0));
    tbl.push_back(mk(0, 0, 16'h0, 1, 4'd15, 16'd0));

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      if (tbl[i].acc) acc(tbl[i].cls);
      if (tbl[i].rd) rd(tbl[i].idx, tbl[i].exp, $sformatf("tbl%0d_idx%0d", i, tbl[i].idx));
    end

    // rd_v_o is a single-cycle pulse and rd_data_o holds while idle (last read returned 0 from idx 15).
    rd(4'd10, 16'd3, "hold_src");
    tick();
    chk("hold_v_low", {31'd0, rd_v_o}, 32'd0);
    chk("hold_data", {16'd0, rd_data_o}, 32'd3);

    // Clear with a same-cycle accept; mid-sweep reads; clear_i pulsed mid-sweep must be ignored.
    do_reset();
    acc(16'h0001); acc(16'h0001);
    acc(16'h0400); acc(16'h0400);
    acc(16'h0004);
    v_i = 1'b1; class_i = 16'h0008; clear_i = 1'b1;
    tick();
    v_i = 1'b0; class_i = 16'h0; clear_i = 1'b0;
    chk("clr_ready_low", {31'd0, ready_o}, 32'd0);
    k = 0;
    while (!ready_o && k < 40) begin
      rd_v_i   = (k == 5) || (k == 6);
      rd_idx_i = (k == 5) ? 4'd0 : 4'd10;
      clear_i  = (k == 8);
      tick();
      k++;
      if (k == 6) chk("clr_mid_e0", {16'd0, rd_data_o}, 32'd0);
      if (k == 7) chk("clr_mid_e10", {16'd0, rd_data_o}, 32'd2);
    end
    rd_v_i = 1'b0; clear_i = 1'b0;
    chk("clr_len", k, n_ent);
    for (int i = 0; i < 12; i++) rd(4'(i), 16'd0, $sformatf("clr_post_e%0d", i));

    // Read/accept collision: the read sees the pre-increment value.
    do_reset();
    for (int i = 0; i < 7; i++) acc(16'h0004);
    v_i = 1'b1; class_i = 16'h0004; rd_v_i = 1'b1; rd_idx_i = 4'd2;
    tick();
    v_i = 1'b0; class_i = 16'h0; rd_v_i = 1'b0;
    chk("coll_same", {16'd0, rd_data_o}, 32'd7);
    rd(4'd2, 16'd8, "coll_next");

    // Async reset mid-sweep and mid-read.
    acc(16'h0400);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    tick(); tick();
    rd_v_i = 1'b1; rd_idx_i = 4'd10;
    tick();
    rd_v_i = 1'b0;
    chk("arst_pre_v", {31'd0, rd_v_o}, 32'd1);
    reset_i = 1'b1;
    #1;
    chk("arst_rd_v", {31'd0, rd_v_o}, 32'd0);
    chk("arst_rd_data", {16'd0, rd_data_o}, 32'd0);
    #3;
    reset_i = 1'b0;
    tick();
    chk("arst_ready", {31'd0, ready_o}, 32'd1);
    rd(4'd2, 16'd0, "arst_e2");
    rd(4'd10, 16'd0, "arst_e10");
    rd(4'd11, 16'd0, "arst_e11");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bsg_fpu_class_stats.md
# bsg_fpu_class_stats

Sequential statistics stage downstream of `bsg_fpu_classify` for half-precision (e=5, m=10) operands. It accepts the 16-bit one-hot RISC-V `fclass` vector over a valid/ready handshake and keeps one saturating occurrence counter per class plus a malformed-input counter. It serves a random-access read port for software or debug visibility. A multi-cycle clear sequencer zeroes the counter file one entry per cycle.

## Interface
- `width_p`, default 16: counter width in bits, minimum 2.
- `clk_i` input 1: clock.
- `reset_i` input 1: asynchronous, active-high reset.
- `v_i` input 1: class vector valid.
- `class_i` input 16: `fclass` vector. Bits 9:0 follow RISC-V ordering (0 = -inf … 9 = qNaN); bits 15:10 are expected zero.
- `ready_o` output 1: stage can accept `class_i`.
- `clear_i` input 1: request to zero all counters.
- `rd_v_i` input 1: read request.
- `rd_idx_i` input 4: counter index to read.
- `rd_v_o` output 1: read data valid.
- `rd_data_o` output `width_p`: read data.

## Operation
- **Counter file:** entries 0–9 are the class counters; entry 10 is the malformed counter; entry 11 is the total counter and exists only when the configuration macro is defined. Every counter is `width_p` bits and saturates at all-ones. A counter never wraps.
- **Accept:** an input is accepted when `v_i & ready_o`. Exactly one of the following happens per accepted input:
  - If `class_i[15:10]` is zero and exactly one bit of `class_i[9:0]` is set, the counter for that bit increments.
  - Otherwise (zero bits set, more than one bit set, or any upper bit set), the malformed counter increments.
- **FSM states:**
  - `eRun`: `ready_o` = 1. A cycle with `clear_i` = 1 moves the FSM to `eClear` with the sweep index at 0.
  - `eClear`: `ready_o` = 0. Each cycle zeroes the entry at the sweep index, then increments the index. After the last implemented entry (10, or 11 with the macro) the FSM returns to `eRun`. `clear_i` is ignored while in `eClear`.
- **Input and clear in the same `eRun` cycle:** the input is counted, and the subsequent sweep clears it.
- **Reads:**
  - `rd_v_i` is always accepted, in any state.
  - `rd_data_o` returns the stored value of entry `rd_idx_i` as it was at the start of the request cycle. A same-cycle increment is not visible.
  - An unimplemented index returns 0, with `rd_v_o` still asserted.
- **Reads during `eClear`:** entries already swept read 0; entries not yet swept read their old value.

## Timing
- **Reset values:** asynchronous reset zeroes all counters, sets the FSM to `eRun`, the sweep index to 0, `rd_v_o` to 0 and `rd_data_o` to 0. `ready_o` is 1 from the first cycle after reset deassertion.
- **Reset mid-sweep:** abandons the sweep. All counters are zero regardless.
- **`ready_o`:** decoded from registered FSM state only, so it has no combinational dependence on `v_i` or `clear_i`.
- **Update latency:** an accepted input is visible to a read issued in the following cycle.
- **Read latency:** 1 cycle. `rd_v_o` and `rd_data_o` are registered. `rd_v_o` is high exactly in the cycle after each `rd_v_i` cycle.
- **`rd_data_o` when idle:** holds its last value when `rd_v_o` is 0.
- **Clear duration:** 11 cycles with `ready_o` = 0, or 12 cycles with the macro, starting the cycle after `clear_i`.

## Configuration
- Macro: `BSG_FPU_CLASS_STATS_TOTAL_EN`.
- **Defined:** entry 11 implements a saturating total counter. It increments on every accepted input, well-formed or malformed. The clear sweep covers entries 0–11.
- **Undefined:** entry 11 is not implemented and reads 0. The clear sweep covers entries 0–10.

## Test plan
- **Increment/readback:** after reset, accept 3 inputs with `class_i` = 0x0001 and 1 input with 0x0200, then read indices 0, 9 and 4 -> returns 3, 1, 0. Each `rd_v_o` pulse is one cycle after its request.
- **Malformed:** accept 0x0000, 0x0003 and 0x0400 -> entry 10 reads 3, all class entries read 0, and entry 11 reads 3 with the macro or 0 without it.
- **Saturation:** with `width_p` = 2, accept 5 inputs of 0x0010 -> entry 4 reads 3.
- **Clear:** load nonzero counts, pulse `clear_i` with `v_i` = 1 carrying 0x0008 in the same cycle -> `ready_o` is low for exactly 11 or 12 cycles, and every entry reads 0 afterward. Read entry 0 and entry 10 mid-sweep at sweep index 5 -> 0 and the old value respectively.
- **Read/accept collision:** entry 2 holds 7; in one cycle accept 0x0004 and read index 2 -> returns 7. A read the next cycle returns 8.
- **Async reset:** assert `reset_i` mid-sweep and mid-read -> `rd_v_o` is 0, all entries are 0 and `ready_o` is 1 on the first cycle after release.
